// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures pulse widths of the demodulated receiver output
// on a microsecond timebase and reports {addr, cmd} with valid/repeat/error strobes.
module nec_ir_decoder #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_US = 12000,
    // Compresses every width window and the timeout by this factor; 1 for real IR timing.
    parameter int TIME_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       frame_valid,
    output logic       rpt_valid,
    output logic       err
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // LEAD_L | inside the 9 ms leader burst
    // LEAD_H | inside the leader space (4.5 ms data / 2.25 ms repeat)
    // BIT_L  | inside a 560 us burst (bit start or stop burst)
    // BIT_H  | inside a bit space, width selects 0 or 1
    // STOP   | frame verdict issued, one cycle back to IDLE
    // RPT_L  | inside the burst closing a repeat code

    localparam int PRESC_MAX = (CLK_FREQ / 1_000_000) - 1;
    localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

    localparam logic [13:0] US_MAX     = 14'h3FFF;
    localparam logic [13:0] LEAD_L_MIN = 14'(8000 / TIME_DIV);
    localparam logic [13:0] LEAD_L_MAX = 14'(10000 / TIME_DIV);
    localparam logic [13:0] LEAD_H_MIN = 14'(4000 / TIME_DIV);
    localparam logic [13:0] LEAD_H_MAX = 14'(5000 / TIME_DIV);
    localparam logic [13:0] RPT_H_MIN  = 14'(1900 / TIME_DIV);
    localparam logic [13:0] RPT_H_MAX  = 14'(2600 / TIME_DIV);
    localparam logic [13:0] BURST_MIN  = 14'(400 / TIME_DIV);
    localparam logic [13:0] BURST_MAX  = 14'(700 / TIME_DIV);
    localparam logic [13:0] ONE_MIN    = 14'(1400 / TIME_DIV);
    localparam logic [13:0] ONE_MAX    = 14'(1900 / TIME_DIV);
    localparam logic [13:0] TIMEOUT_T  = 14'(TIMEOUT_US / TIME_DIV);

    typedef enum logic [2:0] {
        IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP, RPT_L
    } state_t;

    state_t      state, state_n;
    logic        s1, s2, s3;
    logic        fall, rise, edge_det, timeout;
    logic [PW-1:0] presc;
    logic [13:0] us_cnt;
    logic [5:0]  bit_cnt, bit_cnt_n;
    logic [31:0] sr, sr_n;
    logic [7:0]  addr_n, cmd_n;
    logic        have_frame, have_n;
    logic        fv_n, rv_n, err_n;
    logic        bit_zero, bit_one;

    function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // The synchronizer tracks the line through reset so no false edge appears on release.
    always_ff @(posedge clk) begin
        s1 <= ir_in;
        s2 <= s1;
        s3 <= s2;
    end

    assign fall     = s3 & ~s2;
    assign rise     = ~s3 & s2;
    assign edge_det = fall | rise;
    assign timeout  = (us_cnt >= TIMEOUT_T);
    assign bit_zero = in_win(us_cnt, BURST_MIN, BURST_MAX);
    assign bit_one  = in_win(us_cnt, ONE_MIN, ONE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (edge_det) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (presc == PW'(PRESC_MAX)) begin
            presc <= '0;
            if (us_cnt != US_MAX) us_cnt <= us_cnt + 14'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        addr_n    = addr;
        cmd_n     = cmd;
        have_n    = have_frame;
        fv_n      = 1'b0;
        rv_n      = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_n = LEAD_L;
            end
            LEAD_L: begin
                if (rise)         state_n = in_win(us_cnt, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
                else if (timeout) state_n = IDLE;
            end
            LEAD_H: begin
                if (fall) begin
                    if (in_win(us_cnt, LEAD_H_MIN, LEAD_H_MAX)) begin
                        state_n   = BIT_L;
                        bit_cnt_n = '0;
                    end else if (in_win(us_cnt, RPT_H_MIN, RPT_H_MAX)) begin
                        state_n = RPT_L;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            BIT_L: begin
                if (rise) begin
                    if (!in_win(us_cnt, BURST_MIN, BURST_MAX)) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else if (bit_cnt == 6'd32) begin
                        // Verdict is registered on the stop-burst rise itself to keep 3-clk latency.
                        state_n = STOP;
                        if (sr[31:24] == ~sr[23:16]) begin
                            addr_n = sr[7:0];
                            cmd_n  = sr[23:16];
                            have_n = 1'b1;
                            fv_n   = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        state_n = BIT_H;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            BIT_H: begin
                if (fall) begin
                    if (bit_zero || bit_one) begin
                        sr_n      = {bit_one, sr[31:1]};
                        bit_cnt_n = bit_cnt + 6'd1;
                        state_n   = BIT_L;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            STOP: begin
                state_n = IDLE;
            end
            RPT_L: begin
                if (rise) begin
                    state_n = IDLE;
                    if (in_win(us_cnt, BURST_MIN, BURST_MAX)) rv_n = have_frame;
                    else                                      err_n = 1'b1;
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            sr          <= '0;
            addr        <= '0;
            cmd         <= '0;
            have_frame  <= 1'b0;
            frame_valid <= 1'b0;
            rpt_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            sr          <= sr_n;
            addr        <= addr_n;
            cmd         <= cmd_n;
            have_frame  <= have_n;
            frame_valid <= fv_n;
            rpt_valid   <= rv_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder with time windows compressed 100x
// (1 clk = 1 tick = 100 us of real IR time) so whole frames stay short.
module tb_nec_ir_decoder;

    localparam int LL_LO = 80, LL_HI = 100, LH_LO = 40, LH_HI = 50, RH_LO = 19, RH_HI = 26;
    localparam int B_LO = 4, B_HI = 7, ONE_LO = 14, ONE_HI = 19, TO_T = 120;
    // 3 edges from line change to counter clear, err registers one edge after the threshold.
    localparam int TO_LAT = TO_T + 4;
    localparam int R_NONE = 0, R_VALID = 1, R_ERR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_in = 1'b1;
    logic [7:0] addr, cmd;
    logic       frame_valid, rpt_valid, err;

    nec_ir_decoder #(.CLK_FREQ(1_000_000), .TIMEOUT_US(12000), .TIME_DIV(100)) dut (
        .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .addr(addr), .cmd(cmd),
        .frame_valid(frame_valid), .rpt_valid(rpt_valid), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int n_fv = 0, n_rv = 0, n_err = 0, n_multi = 0, n_long = 0, n_spur = 0;
    int s_fv, s_rv, s_err;
    int cyc = 0, err_cyc = 0;
    logic       rst_at_edge = 1'b0;
    logic [7:0] p_addr = 8'h00, p_cmd = 8'h00;
    logic       p_fv = 1'b0, p_rv = 1'b0, p_err = 1'b0;
    logic [7:0] m_addr = 8'h00, m_cmd = 8'h00;
    logic       m_have = 1'b0;
    int burst_w[33];
    int high_w[32];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    always @(negedge clk) begin
        if (frame_valid) n_fv <= n_fv + 1;
        if (rpt_valid) n_rv <= n_rv + 1;
        if (err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if ((int'(frame_valid) + int'(rpt_valid) + int'(err)) > 1) n_multi <= n_multi + 1;
        if ((frame_valid && p_fv) || (rpt_valid && p_rv) || (err && p_err)) n_long <= n_long + 1;
        if (rst_at_edge && !frame_valid && (addr !== p_addr || cmd !== p_cmd)) n_spur <= n_spur + 1;
        p_addr <= addr;
        p_cmd  <= cmd;
        p_fv   <= frame_valid;
        p_rv   <= rpt_valid;
        p_err  <= err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_fv  = n_fv;
        s_rv  = n_rv;
        s_err = n_err;
    endtask

    task automatic check_events(input string tag, input int efv, input int erv, input int eerr);
        check({tag, ".fv"}, n_fv - s_fv, efv);
        check({tag, ".rv"}, n_rv - s_rv, erv);
        check({tag, ".err"}, n_err - s_err, eerr);
        check({tag, ".addr"}, addr, m_addr);
        check({tag, ".cmd"}, cmd, m_cmd);
    endtask

    task automatic send_seg(input logic level, input int m);
        ir_in = level;
        repeat (m + 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        ir_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic int urange(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic inw(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    task automatic fill_frame(input logic [31:0] word, input logic rnd);
        for (int i = 0; i < 32; i++) begin
            burst_w[i] = rnd ? urange(B_LO, B_HI) : 6;
            if (word[i]) high_w[i] = rnd ? urange(ONE_LO, ONE_HI) : 17;
            else         high_w[i] = rnd ? urange(B_LO, B_HI) : 6;
        end
        burst_w[32] = rnd ? urange(B_LO, B_HI) : 6;
    endtask

    // Outcome of a data frame derived from the NEC window rules alone.
    function automatic int classify(input int ll, input int lh, output logic [31:0] w);
        w = '0;
        if (!inw(ll, LL_LO, LL_HI)) return R_NONE;
        if (!inw(lh, LH_LO, LH_HI)) return R_ERR;
        for (int i = 0; i < 32; i++) begin
            if (!inw(burst_w[i], B_LO, B_HI)) return R_ERR;
            if (inw(high_w[i], ONE_LO, ONE_HI))  w[i] = 1'b1;
            else if (!inw(high_w[i], B_LO, B_HI)) return R_ERR;
        end
        if (!inw(burst_w[32], B_LO, B_HI)) return R_ERR;
        return (w[31:24] == ~w[23:16]) ? R_VALID : R_ERR;
    endfunction

    task automatic drive_frame(input int ll, input int lh, input int rst_bit);
        send_seg(1'b0, ll);
        send_seg(1'b1, lh);
        for (int i = 0; i < 32; i++) begin
            if (i == rst_bit) begin
                ir_in = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_mid.addr", addr, 0);
                check("rst_mid.cmd", cmd, 0);
                check("rst_mid.strobes", {frame_valid, rpt_valid, err}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (burst_w[i] - 2) @(negedge clk);
            end else begin
                send_seg(1'b0, burst_w[i]);
            end
            send_seg(1'b1, high_w[i]);
        end
        send_seg(1'b0, burst_w[32]);
        ir_in = 1'b1;
    endtask

    task automatic apply_model(input int r, input logic [31:0] w);
        if (r == R_VALID) begin
            m_addr = w[7:0];
            m_cmd  = w[23:16];
            m_have = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input int ll, input int lh);
        int r;
        logic [31:0] w;
        snap();
        drive_frame(ll, lh, -1);
        idle(30);
        r = classify(ll, lh, w);
        apply_model(r, w);
        check_events(tag, int'(r == R_VALID), 0, int'(r == R_ERR));
    endtask

    task automatic run_repeat(input string tag, input int lh, input int bw);
        int erv, eerr;
        erv  = 0;
        eerr = 0;
        if (!inw(lh, RH_LO, RH_HI) || !inw(bw, B_LO, B_HI)) eerr = 1;
        else if (m_have) erv = 1;
        snap();
        send_seg(1'b0, 90);
        send_seg(1'b1, lh);
        send_seg(1'b0, bw);
        idle(30);
        check_events(tag, 0, erv, eerr);
    endtask

    function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    initial begin
        int t0, ll, lh, k, r;
        logic [7:0] a, c, ai, ci;
        logic [31:0] w;

        rst_n = 1'b0;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.addr", addr, 0);
        check("rst.cmd", cmd, 0);
        check("rst.strobes", {frame_valid, rpt_valid, err}, 0);
        rst_n = 1'b1;
        idle(5);

        run_repeat("t3.rpt_after_reset", 22, 6);

        fill_frame({8'hBA, 8'h45, 8'hFF, 8'h00}, 1'b0);
        snap();
        drive_frame(90, 45, -1);
        @(posedge clk);
        @(posedge clk);
        #1 check("t1.lat2", frame_valid, 0);
        @(posedge clk);
        #1 check("t1.lat3", frame_valid, 1);
        @(posedge clk);
        #1 check("t1.one_cycle", frame_valid, 0);
        idle(30);
        r = classify(90, 45, w);
        apply_model(r, w);
        check_events("t1.frame", 1, 0, 0);
        check("t1.cmd_const", cmd, 8'h45);

        fill_frame(nec_word(8'h07, 8'h16), 1'b0);
        run_frame("t2.frame", 90, 45);
        run_repeat("t2.rpt", 22, 6);
        check("t2.addr_const", addr, 8'h07);

        fill_frame({8'hBB, 8'h45, 8'hF8, 8'h07}, 1'b0);
        run_frame("t4.bad_inv", 90, 45);

        snap();
        send_seg(1'b0, 3);
        idle(30);
        check_events("t5.glitch", 0, 0, 0);

        fill_frame(32'h0, 1'b0);
        snap();
        send_seg(1'b0, 90);
        send_seg(1'b1, 45);
        for (int i = 0; i < 15; i++) begin
            send_seg(1'b0, burst_w[i]);
            send_seg(1'b1, high_w[i]);
        end
        send_seg(1'b0, burst_w[15]);
        ir_in = 1'b1;
        t0 = cyc;
        idle(200);
        check_events("t5.truncated", 0, 0, 1);
        check("t5.timeout_lat", err_cyc - t0, TO_LAT);

        fill_frame(nec_word(8'h01, 8'h02), 1'b0);
        snap();
        drive_frame(90, 45, 10);
        idle(30);
        m_addr = 8'h00;
        m_cmd  = 8'h00;
        m_have = 1'b0;
        check_events("t6.aborted", 0, 0, 0);
        run_repeat("t6.rpt_no_frame", 22, 6);
        fill_frame(nec_word(8'h01, 8'h02), 1'b0);
        run_frame("t6.frame", 90, 45);

        // Boundary windows; 0x3C low byte puts a '0' at bit 0 and a '1' at bit 2.
        w = nec_word(8'h3C, 8'h5A);
        fill_frame(w, 1'b0); run_frame("b.ll79", 79, 45);
        fill_frame(w, 1'b0); run_frame("b.ll80", 80, 45);
        fill_frame(w, 1'b0); run_frame("b.ll100", 100, 40);
        fill_frame(w, 1'b0); run_frame("b.ll101", 101, 45);
        fill_frame(w, 1'b0); run_frame("b.lh39", 90, 39);
        fill_frame(w, 1'b0); run_frame("b.lh50", 90, 50);
        fill_frame(w, 1'b0); run_frame("b.lh51", 90, 51);
        fill_frame(w, 1'b0); burst_w[0] = 3;  run_frame("b.burst3", 90, 45);
        fill_frame(w, 1'b0); burst_w[0] = 4;  burst_w[5] = 7; run_frame("b.burst47", 90, 45);
        fill_frame(w, 1'b0); burst_w[32] = 8; run_frame("b.stop8", 90, 45);
        fill_frame(w, 1'b0); high_w[0] = 8;   run_frame("b.zero8", 90, 45);
        fill_frame(w, 1'b0); high_w[2] = 13;  run_frame("b.one13", 90, 45);
        fill_frame(w, 1'b0); high_w[2] = 20;  run_frame("b.one20", 90, 45);
        fill_frame(w, 1'b0); high_w[0] = 4; high_w[1] = 7; high_w[2] = 14; high_w[3] = 19;
        run_frame("b.bit_edges", 90, 45);
        run_repeat("b.rpt_lh18", 18, 6);
        run_repeat("b.rpt_lh19", 19, 4);
        run_repeat("b.rpt_lh26", 26, 7);
        run_repeat("b.rpt_lh27", 27, 6);
        run_repeat("b.rpt_b3", 22, 3);
        run_repeat("b.rpt_b8", 22, 8);

        for (int n = 0; n < 20; n++) begin
            a  = 8'(urange(0, 255));
            c  = 8'(urange(0, 255));
            ai = (urange(0, 1) == 1) ? ~a : 8'(urange(0, 255));
            ci = (urange(0, 3) == 0) ? (~c ^ 8'(urange(1, 255))) : ~c;
            fill_frame({ci, c, ai, a}, 1'b1);
            if (urange(0, 3) == 0) ll = (urange(0, 1) == 1) ? urange(70, 79) : urange(101, 110);
            else                   ll = urange(LL_LO, LL_HI);
            lh = urange(LH_LO, LH_HI);
            if (urange(0, 4) == 0) begin
                k = urange(0, 31);
                high_w[k] = (urange(0, 1) == 1) ? urange(8, 13) : urange(20, 23);
            end
            run_frame($sformatf("rnd%0d.frame", n), ll, lh);
            if (urange(0, 2) == 0)
                run_repeat($sformatf("rnd%0d.rpt", n), urange(RH_LO, RH_HI), urange(B_LO, B_HI));
        end

        check("mon.exclusive", n_multi, 0);
        check("mon.pulse_width", n_long, 0);
        check("mon.addr_cmd_stable", n_spur, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
